imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
Parametrised, pipelined successor to the single-cycle immediate sign extender. Accepts a 26-bit instruction immediate field plus a 3-bit format select, produces a DATA_W-wide extended immediate, and adds MOVZ-style shifted and zero-extended modes. Registered output behind a valid/ready handshake with a 2-entry skid buffer, so it sits between decode and the execute-stage operand mux of the pipelined datapath.

Parameters:
DATA_W, 64, output immediate width; legal 32 or 64
ERR_ON_BAD_HW, 1, flag MOVZ hw values that shift outside DATA_W

Ports:
CLK  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
in_valid  input  1  Imm26/Ctrl valid this cycle
in_ready  output  1  block can accept an input this cycle
Imm26  input  26  instruction bits [25:0]
Ctrl  input  3  format select (see Behaviour)
out_valid  output  1  BusImm/out_ctrl valid
out_ready  input  1  consumer accepts output this cycle
BusImm  output  DATA_W  extended immediate
out_ctrl  output  3  Ctrl that produced BusImm
err_sticky  output  1  reserved Ctrl or illegal hw seen since reset

Behaviour:
- Ctrl encodings (sign extension from the stated MSB to DATA_W):
  000 I: sign-extend Imm26[21:10]
  001 D: sign-extend Imm26[20:12]
  010 B: sign-extend Imm26[25:0]
  011 CB: sign-extend Imm26[23:5]
  100 IW: zero-extend Imm26[20:5], shifted left by 16*Imm26[22:21]
  101 IL: zero-extend Imm26[21:10] (logical immediates)
  110, 111 reserved: BusImm = 0, err_sticky set on acceptance
- IW with DATA_W=32 and hw >= 2: BusImm = 0; err_sticky set if ERR_ON_BAD_HW=1.
- Transfer rules: input accepted when in_valid & in_ready; output consumed when out_valid & out_ready. Producer holds Imm26/Ctrl stable while in_valid & ~in_ready.
- Latency: 1 cycle. An input accepted at edge N appears on BusImm with out_valid=1 after edge N.
- States: EMPTY (no data), ONE (output reg full), FULL (output reg + skid full). in_ready = (state != FULL), decoded from registered state only, with no combinational path from out_ready.
  EMPTY: accept -> ONE.
  ONE: accept & consume -> ONE (output reg reloads); accept only -> FULL (new item to skid); consume only -> EMPTY; neither -> ONE.
  FULL: consume -> ONE (skid moves to output reg); otherwise stay. No accept possible.
- Order strictly FIFO; no item dropped or duplicated.
- BusImm/out_ctrl hold their value while out_valid & ~out_ready.
- Reset (any time, including mid-transfer): state EMPTY, out_valid=0, BusImm=0, out_ctrl=0, skid contents=0, err_sticky=0; in_ready=1 once in EMPTY. In-flight items are discarded.
- err_sticky clears only on Reset.

Decomposition:
- Package imm_ext_pkg: Ctrl encoding constants (CTRL_I, CTRL_D, CTRL_B, CTRL_CB, CTRL_IW, CTRL_IL), skid state encoding (ST_EMPTY, ST_ONE, ST_FULL).
- Sub-module imm_extend_core: purely combinational, parametrised by DATA_W, maps Imm26/Ctrl to immediate plus an err bit. imm_extend_pipe instantiates it at the input side and registers its outputs into the output/skid registers.

Test Plan:
- DATA_W=64, out_ready=1, Ctrl=000, Imm26=26'h03FFC00 -> next cycle out_valid=1, BusImm=64'hFFFF_FFFF_FFFF_FFFF; then Ctrl=101 with the same Imm26 -> BusImm=64'h0000_0000_0000_0FFF.
- Ctrl=001, Imm26=26'h0100000 -> BusImm=64'hFFFF_FFFF_FFFF_FF00; Ctrl=010, Imm26=26'h2000000 -> BusImm=64'hFFFF_FFFF_FE00_0000.
- Ctrl=100, Imm26=26'h077DDE0 (hw=3, imm16=BEEF) -> BusImm=64'hBEEF_0000_0000_0000; with DATA_W=32 -> BusImm=0 and err_sticky=1.
- Back-to-back items A,B,C with out_ready=0 for 3 cycles -> A and B accepted, in_ready=0 after B, C held; release out_ready -> A, B, C emitted in order, one per cycle.
- Ctrl=110 accepted -> BusImm=0, out_ctrl=3'b110, err_sticky=1 and still 1 after 10 further legal items.
- Reset asserted asynchronously in state FULL -> out_valid=0, BusImm=0, err_sticky=0 immediately without a clock edge; in_ready=1; no stale item emitted after release.

Source files
------------

// File: rtl/imm_extend_pipe_pkg.sv
// rtl/imm_extend_pipe_pkg.sv - format select encodings and skid buffer states for imm_extend_pipe
package imm_ext_pkg;

    localparam logic [2:0] CTRL_I  = 3'b000;  // sign-extend Imm26[21:10]
    localparam logic [2:0] CTRL_D  = 3'b001;  // sign-extend Imm26[20:12]
    localparam logic [2:0] CTRL_B  = 3'b010;  // sign-extend Imm26[25:0]
    localparam logic [2:0] CTRL_CB = 3'b011;  // sign-extend Imm26[23:5]
    localparam logic [2:0] CTRL_IW = 3'b100;  // zero-extend Imm26[20:5] << 16*hw
    localparam logic [2:0] CTRL_IL = 3'b101;  // zero-extend Imm26[21:10]

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,  // nothing held
        ST_ONE   = 2'd1,  // output register full
        ST_FULL  = 2'd2   // output register and skid register full
    } skid_state_t;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// rtl/imm_extend_pipe_if.sv - input/output handshake bundle of imm_extend_pipe
// Ports: in_valid/in_ready/Imm26/Ctrl (request side), out_valid/out_ready/BusImm/
// out_ctrl (result side), err_sticky (status). slave = design side, master = driver side.
interface imm_extend_pipe_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [25:0]       Imm26;
    logic [2:0]        Ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] BusImm;
    logic [2:0]        out_ctrl;
    logic              err_sticky;

    modport slave (
        input  in_valid, Imm26, Ctrl, out_ready,
        output in_ready, out_valid, BusImm, out_ctrl, err_sticky
    );

    modport master (
        output in_valid, Imm26, Ctrl, out_ready,
        input  in_ready, out_valid, BusImm, out_ctrl, err_sticky
    );
endinterface

// File: rtl/imm_extend_pipe_core.sv
// rtl/imm_extend_pipe_core.sv - combinational Imm26/Ctrl to DATA_W immediate mapping
// Ports: imm26 (instruction bits 25:0), ctrl (format select), imm (extended
// immediate), err (reserved format or MOVZ shift that leaves the word).
module imm_extend_core
    import imm_ext_pkg::*;
#(
    parameter int DATA_W        = 64,
    parameter bit ERR_ON_BAD_HW = 1'b1
) (
    input  logic [25:0]       imm26,
    input  logic [2:0]        ctrl,
    output logic [DATA_W-1:0] imm,
    output logic              err
);

    // MOVZ result is built at the widest legal size and truncated afterwards.
    logic [63:0] iw_wide;

    always_comb begin
        imm     = '0;
        err     = 1'b0;
        iw_wide = {48'b0, imm26[20:5]} << {imm26[22:21], 4'b0000};
        case (ctrl)
            CTRL_I:  imm = {{(DATA_W-12){imm26[21]}}, imm26[21:10]};
            CTRL_D:  imm = {{(DATA_W-9){imm26[20]}}, imm26[20:12]};
            CTRL_B:  imm = {{(DATA_W-26){imm26[25]}}, imm26};
            CTRL_CB: imm = {{(DATA_W-19){imm26[23]}}, imm26[23:5]};
            CTRL_IW: begin
                // A 32-bit word only has halfword slots 0 and 1.
                if (DATA_W == 32 && imm26[22]) begin
                    err = ERR_ON_BAD_HW;
                end else begin
                    imm = iw_wide[DATA_W-1:0];
                end
            end
            CTRL_IL: imm = {{(DATA_W-12){1'b0}}, imm26[21:10]};
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - registered immediate extender with 2-entry skid buffer
// Ports: CLK, Reset (async, active high), io (imm_extend_pipe_if.slave):
// Imm26/Ctrl in under in_valid/in_ready, BusImm/out_ctrl out under
// out_valid/out_ready, err_sticky set by reserved Ctrl or illegal MOVZ hw.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int DATA_W        = 64,
    parameter bit ERR_ON_BAD_HW = 1'b1
) (
    input  logic              CLK,
    input  logic              Reset,
    imm_extend_pipe_if.slave  io
);

    skid_state_t       state;
    logic [DATA_W-1:0] core_imm;
    logic              core_err;
    logic [DATA_W-1:0] out_imm;
    logic [2:0]        out_ctrl_r;
    logic [DATA_W-1:0] skid_imm;
    logic [2:0]        skid_ctrl;
    logic              err_r;
    logic              accept;
    logic              consume;

    imm_extend_core #(
        .DATA_W        (DATA_W),
        .ERR_ON_BAD_HW (ERR_ON_BAD_HW)
    ) u_core (
        .imm26 (io.Imm26),
        .ctrl  (io.Ctrl),
        .imm   (core_imm),
        .err   (core_err)
    );

    // Both handshake outputs come from the state register only, so out_ready
    // never reaches in_ready combinationally.
    assign io.in_ready   = (state != ST_FULL);
    assign io.out_valid  = (state != ST_EMPTY);
    assign io.BusImm     = out_imm;
    assign io.out_ctrl   = out_ctrl_r;
    assign io.err_sticky = err_r;

    assign accept  = io.in_valid & io.in_ready;
    assign consume = io.out_valid & io.out_ready;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= ST_EMPTY;
            out_imm    <= '0;
            out_ctrl_r <= '0;
            skid_imm   <= '0;
            skid_ctrl  <= '0;
            err_r      <= 1'b0;
        end else begin
            if (accept && core_err) begin
                err_r <= 1'b1;
            end
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out_imm    <= core_imm;
                        out_ctrl_r <= io.Ctrl;
                        state      <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        out_imm    <= core_imm;
                        out_ctrl_r <= io.Ctrl;
                    end else if (accept) begin
                        skid_imm  <= core_imm;
                        skid_ctrl <= io.Ctrl;
                        state     <= ST_FULL;
                    end else if (consume) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        out_imm    <= skid_imm;
                        out_ctrl_r <= skid_ctrl;
                        state      <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - self-checking bench for imm_extend_pipe (64- and 32-bit instances)
module tb_imm_extend_pipe;

    logic CLK;
    logic Reset;
    int   checks;
    int   fails;
    bit   err_exp;

    imm_extend_pipe_if #(.DATA_W(64)) bus64 ();
    imm_extend_pipe_if #(.DATA_W(32)) bus32 ();

    imm_extend_pipe #(.DATA_W(64), .ERR_ON_BAD_HW(1'b1)) dut64 (
        .CLK   (CLK),
        .Reset (Reset),
        .io    (bus64.slave)
    );

    imm_extend_pipe #(.DATA_W(32), .ERR_ON_BAD_HW(1'b1)) dut32 (
        .CLK   (CLK),
        .Reset (Reset),
        .io    (bus32.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic longint sext(input longint v, input int n);
        if (v >= (longint'(1) << (n - 1))) return v - (longint'(1) << n);
        return v;
    endfunction

    // Reference for a 64-bit result, computed from the format rules.
    function automatic logic [63:0] model(input logic [2:0] c, input logic [25:0] imm);
        longint v;
        longint hw;
        v  = longint'(imm);
        hw = (v >> 21) & 3;
        case (c)
            3'd0:    return sext((v >> 10) & 'hFFF, 12);
            3'd1:    return sext((v >> 12) & 'h1FF, 9);
            3'd2:    return sext(v, 26);
            3'd3:    return sext((v >> 5) & 'h7FFFF, 19);
            3'd4:    return ((v >> 5) & 'hFFFF) * (longint'(1) << (16 * hw));
            3'd5:    return (v >> 10) & 'hFFF;
            default: return 64'd0;
        endcase
    endfunction

    task automatic test_reset();
        Reset = 1'b1;
        bus64.in_valid = 0; bus64.Imm26 = '0; bus64.Ctrl = '0; bus64.out_ready = 0;
        bus32.in_valid = 0; bus32.Imm26 = '0; bus32.Ctrl = '0; bus32.out_ready = 1;
        #3;
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        checks++; if (bus64.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus64.in_ready); end
        checks++; if (bus64.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus64.out_valid); end
        checks++; if (bus64.BusImm !== 64'd0) begin fails++; $display("FAIL reset_busimm got %h want 0", bus64.BusImm); end
        checks++; if (bus64.out_ctrl !== 3'd0) begin fails++; $display("FAIL reset_out_ctrl got %b want 000", bus64.out_ctrl); end
        checks++; if (bus64.err_sticky !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", bus64.err_sticky); end
    endtask

    task automatic test_formats();
        logic [2:0]  c [6];
        logic [25:0] im [6];
        logic [63:0] ex [6];
        c[0] = 3'b000; im[0] = 26'h03FFC00; ex[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        c[1] = 3'b101; im[1] = 26'h03FFC00; ex[1] = 64'h0000_0000_0000_0FFF;
        c[2] = 3'b001; im[2] = 26'h0100000; ex[2] = 64'hFFFF_FFFF_FFFF_FF00;
        c[3] = 3'b010; im[3] = 26'h2000000; ex[3] = 64'hFFFF_FFFF_FE00_0000;
        c[4] = 3'b100; im[4] = 26'h077DDE0; ex[4] = 64'hBEEF_0000_0000_0000;
        c[5] = 3'b011; im[5] = 26'h0800000; ex[5] = 64'hFFFF_FFFF_FFFC_0000;
        for (int i = 0; i < 6; i++) begin
            bus64.in_valid = 1; bus64.Ctrl = c[i]; bus64.Imm26 = im[i]; bus64.out_ready = 1;
            @(negedge CLK);
            bus64.in_valid = 0;
            checks++; if (bus64.out_valid !== 1'b1) begin fails++; $display("FAIL fmt%0d_out_valid got %b want 1", i, bus64.out_valid); end
            checks++; if (bus64.BusImm !== ex[i]) begin fails++; $display("FAIL fmt%0d_busimm got %h want %h", i, bus64.BusImm, ex[i]); end
            checks++; if (bus64.out_ctrl !== c[i]) begin fails++; $display("FAIL fmt%0d_out_ctrl got %b want %b", i, bus64.out_ctrl, c[i]); end
        end
        @(negedge CLK);
        checks++; if (bus64.out_valid !== 1'b0) begin fails++; $display("FAIL fmt_drain got %b want 0", bus64.out_valid); end
        checks++; if (bus64.err_sticky !== 1'b0) begin fails++; $display("FAIL fmt_err got %b want 0", bus64.err_sticky); end
    endtask

    task automatic test_iw32();
        bus32.in_valid = 1; bus32.Ctrl = 3'b000; bus32.Imm26 = 26'h03FFC00;
        @(negedge CLK);
        checks++; if (bus32.BusImm !== 32'hFFFF_FFFF) begin fails++; $display("FAIL w32_i got %h want ffffffff", bus32.BusImm); end
        checks++; if (bus32.err_sticky !== 1'b0) begin fails++; $display("FAIL w32_err_pre got %b want 0", bus32.err_sticky); end
        bus32.Ctrl = 3'b100; bus32.Imm26 = 26'h077DDE0;
        @(negedge CLK);
        bus32.in_valid = 0;
        checks++; if (bus32.out_valid !== 1'b1) begin fails++; $display("FAIL w32_iw_valid got %b want 1", bus32.out_valid); end
        checks++; if (bus32.BusImm !== 32'd0) begin fails++; $display("FAIL w32_iw_busimm got %h want 0", bus32.BusImm); end
        checks++; if (bus32.err_sticky !== 1'b1) begin fails++; $display("FAIL w32_iw_err got %b want 1", bus32.err_sticky); end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  c [3];
        logic [25:0] im [3];
        for (int i = 0; i < 3; i++) begin
            c[i]  = 3'($urandom_range(0, 5));
            im[i] = 26'($urandom);
        end
        bus64.out_ready = 0;
        bus64.in_valid = 1; bus64.Ctrl = c[0]; bus64.Imm26 = im[0];
        @(negedge CLK);
        checks++; if (bus64.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_one got %b want 1", bus64.in_ready); end
        bus64.Ctrl = c[1]; bus64.Imm26 = im[1];
        @(negedge CLK);
        checks++; if (bus64.in_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_full got %b want 0", bus64.in_ready); end
        bus64.Ctrl = c[2]; bus64.Imm26 = im[2];
        @(negedge CLK);
        checks++; if (bus64.in_ready !== 1'b0) begin fails++; $display("FAIL b2b_c_held got %b want 0", bus64.in_ready); end
        bus64.out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus64.out_valid !== 1'b1 || bus64.BusImm !== model(c[k], im[k]) || bus64.out_ctrl !== c[k]) begin
                fails++;
                $display("FAIL b2b_item%0d got v=%b %h/%b want v=1 %h/%b", k, bus64.out_valid, bus64.BusImm, bus64.out_ctrl, model(c[k], im[k]), c[k]);
            end
            @(negedge CLK);
            if (k == 1) bus64.in_valid = 0;
        end
        checks++; if (bus64.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b want 0", bus64.out_valid); end
    endtask

    task automatic run_random(input int n, input bit legal_only);
        logic [63:0] q_imm [$];
        logic [2:0]  q_ctrl [$];
        bit          pa, pc;
        logic [2:0]  pctrl;
        logic [25:0] pimm;
        pa = 0; pc = 0; pctrl = '0; pimm = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (pc && q_imm.size() != 0) begin q_imm.pop_front(); q_ctrl.pop_front(); end
            if (pa) begin
                q_imm.push_back(model(pctrl, pimm));
                q_ctrl.push_back(pctrl);
                if (pctrl >= 3'd6) err_exp = 1;
            end
            checks++; if (bus64.out_valid !== (q_imm.size() != 0)) begin fails++; $display("FAIL rnd_out_valid cyc%0d got %b want %b", i, bus64.out_valid, q_imm.size() != 0); end
            checks++; if (bus64.in_ready !== (q_imm.size() < 2)) begin fails++; $display("FAIL rnd_in_ready cyc%0d got %b want %b", i, bus64.in_ready, q_imm.size() < 2); end
            checks++; if (bus64.err_sticky !== err_exp) begin fails++; $display("FAIL rnd_err cyc%0d got %b want %b", i, bus64.err_sticky, err_exp); end
            if (bus64.out_valid === 1'b1 && q_imm.size() != 0) begin
                checks++;
                if (bus64.BusImm !== q_imm[0] || bus64.out_ctrl !== q_ctrl[0]) begin
                    fails++;
                    $display("FAIL rnd_data cyc%0d got %h/%b want %h/%b", i, bus64.BusImm, bus64.out_ctrl, q_imm[0], q_ctrl[0]);
                end
            end
            if (i >= n - 4) begin
                bus64.in_valid = 0;
                bus64.out_ready = 1;
            end else begin
                // A producer must hold an offered item until it is taken.
                if (!(bus64.in_valid && !pa)) begin
                    bus64.in_valid = ($urandom_range(0, 3) != 0);
                    bus64.Ctrl     = legal_only ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
                    bus64.Imm26    = 26'($urandom);
                end
                bus64.out_ready = ($urandom_range(0, 3) != 0);
            end
            pa = bus64.in_valid & bus64.in_ready;
            pc = bus64.out_valid & bus64.out_ready;
            pctrl = bus64.Ctrl;
            pimm  = bus64.Imm26;
        end
    endtask

    task automatic test_reserved();
        bus64.in_valid = 1; bus64.Ctrl = 3'b110; bus64.Imm26 = 26'($urandom); bus64.out_ready = 1;
        @(negedge CLK);
        bus64.in_valid = 0;
        checks++; if (bus64.BusImm !== 64'd0) begin fails++; $display("FAIL rsv_busimm got %h want 0", bus64.BusImm); end
        checks++; if (bus64.out_ctrl !== 3'b110) begin fails++; $display("FAIL rsv_out_ctrl got %b want 110", bus64.out_ctrl); end
        checks++; if (bus64.err_sticky !== 1'b1) begin fails++; $display("FAIL rsv_err got %b want 1", bus64.err_sticky); end
        err_exp = 1;
        run_random(40, 1'b1);
        checks++; if (bus64.err_sticky !== 1'b1) begin fails++; $display("FAIL rsv_err_sticky got %b want 1", bus64.err_sticky); end
    endtask

    task automatic test_async_reset();
        bus64.out_ready = 0;
        bus64.in_valid = 1; bus64.Ctrl = 3'b000; bus64.Imm26 = 26'h0123456;
        @(negedge CLK);
        bus64.Imm26 = 26'h0654321;
        @(negedge CLK);
        bus64.in_valid = 0;
        checks++; if (bus64.in_ready !== 1'b0) begin fails++; $display("FAIL ar_full got %b want 0", bus64.in_ready); end
        #2 Reset = 1'b1;
        #1;
        checks++; if (bus64.out_valid !== 1'b0) begin fails++; $display("FAIL ar_out_valid got %b want 0", bus64.out_valid); end
        checks++; if (bus64.BusImm !== 64'd0) begin fails++; $display("FAIL ar_busimm got %h want 0", bus64.BusImm); end
        checks++; if (bus64.err_sticky !== 1'b0) begin fails++; $display("FAIL ar_err got %b want 0", bus64.err_sticky); end
        checks++; if (bus64.in_ready !== 1'b1) begin fails++; $display("FAIL ar_in_ready got %b want 1", bus64.in_ready); end
        err_exp = 0;
        @(negedge CLK);
        Reset = 1'b0;
        bus64.out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            checks++; if (bus64.out_valid !== 1'b0) begin fails++; $display("FAIL ar_stale%0d got %b want 0", k, bus64.out_valid); end
        end
    endtask

    initial begin
        checks = 0; fails = 0; err_exp = 0;
        test_reset();
        test_formats();
        test_iw32();
        test_back_to_back();
        run_random(400, 1'b1);
        test_reserved();
        run_random(400, 1'b0);
        test_async_reset();
        run_random(100, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
